// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear-FSM state encoding,
// default geometry and the depth helper.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Read/write/status bundle between the decode stage (master) and the register file (slave).
interface param_register_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy;
    logic                     wr_drop;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, busy, wr_drop
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, busy, wr_drop
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every array address once with a zero write, then idles.
//   state    | meaning
//   ST_CLEAR | zeroing array[clear_idx] each cycle, busy=1
//   ST_RUN   | sweep finished, user writes allowed, busy=0
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam int                DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clear_idx, clear_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= state_nxt;
            clear_idx <= clear_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_idx_nxt = clear_idx;
        case (state)
            ST_CLEAR: begin
                clear_idx_nxt = clear_idx + 1'b1;
                if (clear_idx == LAST) state_nxt = ST_RUN;
            end
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // The array must stay untouched on a reset edge, hence the rst qualifier.
    always_comb begin
        busy     = (state == ST_CLEAR);
        clr_we   = (state == ST_CLEAR) && !rst;
        clr_addr = clear_idx;
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with hardware clear after reset.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle write hits.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    param_register_file_if.slave  bus
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              zero_wr;
    logic              user_we;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy = busy;
    assign zero_wr  = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign user_we  = bus.wr_en && !busy && !zero_wr && !rst;

    // Clear sweep owns the write port while busy; user writes are dropped then.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bus.wr_drop <= 1'b0;
        else     bus.wr_drop <= bus.wr_en && (busy || zero_wr);
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] rd_q;

        assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign hit = user_we && (ra == bus.wr_addr);
`else
        assign hit = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst || busy) begin
                rd_q <= '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_q <= '0;
            end else if (hit) begin
                rd_q <= bus.wr_data;
            end else begin
                rd_q <= mem[ra];
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench: two builds (8x16/2-port/zero-reg and 32x32/3-port/plain) against an
// array-and-countdown reference model; expectations queued at drive time, checked by a monitor.
module tb_param_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic            busy;
        logic            drop;
        logic [2:0][31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    param_register_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) bus_a ();
    param_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus_b ();

    param_register_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk (clk), .rst (rst_a), .bus (bus_a)
    );
    param_register_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clk (clk), .rst (rst_b), .bus (bus_b)
    );

    int cfg_aw [2] = '{3, 5};
    int cfg_dw [2] = '{16, 32};
    int cfg_nr [2] = '{2, 3};
    int cfg_zr [2] = '{1, 0};

    // stimulus for the coming edge, per build
    logic        s_rst [2];
    logic        s_we  [2];
    int          s_wa  [2];
    logic [31:0] s_wd  [2];
    int          s_ra  [2][3];

    // reference model: register contents plus remaining clear cycles
    logic [31:0] m_mem  [2][32];
    int          m_left [2];
    int          m_pos  [2];

    exp_t q_a[$];
    exp_t q_b[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    endtask

    task automatic model_step(input int d, output exp_t e);
        int          depth;
        logic [31:0] mask;
        bit          drop;
        depth = 1 << cfg_aw[d];
        mask  = (cfg_dw[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[d]) - 32'd1);
        e     = '0;
        if (s_rst[d]) begin
            m_left[d] = depth;
            m_pos[d]  = 0;
            e.busy    = 1'b1;
        end else if (m_left[d] > 0) begin
            m_mem[d][m_pos[d]] = 32'd0;
            m_pos[d]++;
            m_left[d]--;
            e.drop = s_we[d];
            e.busy = (m_left[d] > 0);
        end else begin
            drop   = s_we[d] && (cfg_zr[d] != 0) && (s_wa[d] == 0);
            e.drop = drop;
            for (int i = 0; i < cfg_nr[d]; i++) begin
                if ((cfg_zr[d] != 0) && (s_ra[d][i] == 0))
                    e.rd[i] = 32'd0;
                else if (BYP && s_we[d] && !drop && (s_ra[d][i] == s_wa[d]))
                    e.rd[i] = s_wd[d] & mask;
                else
                    e.rd[i] = m_mem[d][s_ra[d][i]];
            end
            if (s_we[d] && !drop) m_mem[d][s_wa[d]] = s_wd[d] & mask;
        end
    endtask

    task automatic drive();
        rst_a         = s_rst[0];
        bus_a.wr_en   = s_we[0];
        bus_a.wr_addr = s_wa[0][2:0];
        bus_a.wr_data = s_wd[0][15:0];
        bus_a.rd_addr = {s_ra[0][1][2:0], s_ra[0][0][2:0]};
        rst_b         = s_rst[1];
        bus_b.wr_en   = s_we[1];
        bus_b.wr_addr = s_wa[1][4:0];
        bus_b.wr_data = s_wd[1];
        bus_b.rd_addr = {s_ra[1][2][4:0], s_ra[1][1][4:0], s_ra[1][0][4:0]};
    endtask

    task automatic set(input int d, input bit r, input bit we, input int wa, input logic [31:0] wd,
                       input int r0, input int r1, input int r2);
        s_rst[d] = r;  s_we[d] = we;  s_wa[d] = wa;  s_wd[d] = wd;
        s_ra[d][0] = r0;  s_ra[d][1] = r1;  s_ra[d][2] = r2;
    endtask

    task automatic tick();
        exp_t e;
        drive();
        model_step(0, e);  q_a.push_back(e);
        model_step(1, e);  q_b.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge the DUTs present busy/wr_drop/rd_data; compare against queued expectations.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("busy", 0, {31'd0, bus_a.busy}, {31'd0, e.busy});
            cmp("wr_drop", 0, {31'd0, bus_a.wr_drop}, {31'd0, e.drop});
            for (int i = 0; i < 2; i++)
                cmp($sformatf("rd_data[%0d]", i), 0, {16'd0, bus_a.rd_data[i*16 +: 16]}, e.rd[i]);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("busy", 1, {31'd0, bus_b.busy}, {31'd0, e.busy});
            cmp("wr_drop", 1, {31'd0, bus_b.wr_drop}, {31'd0, e.drop});
            for (int i = 0; i < 3; i++)
                cmp($sformatf("rd_data[%0d]", i), 1, bus_b.rd_data[i*32 +: 32], e.rd[i]);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) set(d, 1'b1, 1'b0, 0, 32'd0, 0, 0, 0);
        // reset two cycles, then let both sweeps run while reading every address
        tick();  tick();
        for (int k = 0; k < 34; k++) begin
            set(0, 1'b0, 1'b0, 0, 32'd0, k % 8, (k + 3) % 8, 0);
            set(1, 1'b0, 1'b0, 0, 32'd0, k % 32, (k + 5) % 32, (k + 9) % 32);
            tick();
        end
        // basic write/read, zero register, wide build
        set(0, 1'b0, 1'b1, 3, 32'h0000_BEEF, 1, 2, 0);
        set(1, 1'b0, 1'b1, 31, 32'hDEAD_BEEF, 1, 2, 3);
        tick();
        set(0, 1'b0, 1'b1, 0, 32'h0000_1234, 3, 3, 0);
        set(1, 1'b0, 1'b1, 17, 32'hA5A5_A5A5, 31, 17, 0);
        tick();
        set(0, 1'b0, 1'b0, 0, 32'd0, 0, 3, 0);
        set(1, 1'b0, 1'b1, 0, 32'h0000_1234, 31, 17, 0);
        tick();
        set(0, 1'b0, 1'b1, 5, 32'h0000_0001, 0, 0, 0);
        set(1, 1'b0, 1'b0, 0, 32'd0, 31, 17, 0);
        tick();
        // same-cycle write/read hit
        set(0, 1'b0, 1'b1, 5, 32'h0000_00FF, 5, 5, 0);
        set(1, 1'b0, 1'b1, 17, 32'h0BAD_F00D, 17, 31, 17);
        tick();
        set(0, 1'b0, 1'b0, 0, 32'd0, 5, 5, 0);
        set(1, 1'b0, 1'b0, 0, 32'd0, 17, 0, 31);
        tick();
        // reset, restart mid-clear, write during busy
        set(0, 1'b1, 1'b0, 0, 32'd0, 5, 3, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set(0, 1'b0, 1'b0, 0, 32'd0, 5, 3, 0);
            tick();
        end
        set(0, 1'b1, 1'b0, 0, 32'd0, 5, 3, 0);
        tick();
        set(0, 1'b0, 1'b1, 2, 32'h0000_7777, 2, 5, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            set(0, 1'b0, 1'b0, 0, 32'd0, 2, 3, 0);
            tick();
        end
        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                int top, wa;
                top = (1 << cfg_aw[d]) - 1;
                wa  = $urandom_range(0, top);
                set(d, ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
                    ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, top),
                    ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, top),
                    $urandom_range(0, top));
            end
            tick();
        end
        for (int d = 0; d < 2; d++) set(d, 1'b0, 1'b0, 0, 32'd0, 0, 0, 0);
        drive();
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d entries left expected 0/0", q_a.size(), q_b.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
